inst_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory that replaces the combinational, hard-initialised instruction ROM.
- Fetch port: word-aligned byte address; registered instruction output one cycle later; stall hold; misalignment and range flags.
- Program-load port: fills the array at run time with auto-incrementing word addresses, so test programs need no re-synthesis.
- Sits between the PC register and the decoder.

---
 rtl/rv_mem_pkg.sv | 17 +
 rtl/inst_mem_array.sv | 29 ++
 rtl/inst_mem_sync.sv | 137 +++++++++++++
 tb/tb_inst_mem_sync.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared constants, mode type and address helper for the instruction memory
package rv_mem_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_LOAD = 1'b1
    } mode_e;

    // Byte address to word index; the caller zero-extends to 32 bits.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - single-port synchronous RAM with write enable and registered read
module inst_mem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = rv_mem_pkg::XLEN
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on an enabled read, so a stalled fetch keeps its word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - synchronous-read instruction memory with fetch faults, stall hold and run-time program load
module inst_mem_sync #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int DATA_W = rv_mem_pkg::XLEN,
    parameter logic [DATA_W-1:0] NOP_WORD = rv_mem_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    input  logic                     stall,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic                     misalign,
    output logic                     out_of_range,
    input  logic                     prog_mode,
    input  logic                     prog_valid,
    input  logic [DATA_W-1:0]        prog_data,
    output logic                     prog_ready,
    output logic [$clog2(DEPTH):0]   prog_count
);

    import rv_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_ram_q, sel_ram_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               valid_q, valid_d;
    logic               mis_q, mis_d;
    logic               oor_q, oor_d;

    logic [31:0]        idx_full;
    logic               fault_mis, fault_oor, accept;
    logic               ram_we, ram_re;
    logic [IDX_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_rdata;

    assign idx_full  = word_index(32'(fetch_addr));
    assign fault_mis = (fetch_addr[1:0] != 2'b00);
    assign fault_oor = (idx_full >= 32'(DEPTH));
    assign accept    = (mode_q == MODE_RUN) && !prog_mode && fetch_req && !stall;

    assign prog_ready = (mode_q == MODE_LOAD) && (cnt_q < CNT_W'(DEPTH));
    assign ram_we     = !reset && prog_valid && prog_ready;
    assign ram_re     = !reset && accept && !fault_mis && !fault_oor;
    assign ram_addr   = (mode_q == MODE_LOAD) ? cnt_q[IDX_W-1:0] : idx_full[IDX_W-1:0];

    inst_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (prog_data),
        .rdata_o (ram_rdata)
    );

    // A good fetch presents the RAM read register directly; everything else comes from hold_q.
    assign instr        = sel_ram_q ? ram_rdata : hold_q;
    assign instr_valid  = valid_q;
    assign misalign     = mis_q;
    assign out_of_range = oor_q;
    assign prog_count   = cnt_q;

    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        sel_ram_d = sel_ram_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        oor_d     = oor_q;
        case (mode_q)
            MODE_RUN: begin
                if (prog_mode) begin
                    mode_d    = MODE_LOAD;
                    cnt_d     = '0;
                    sel_ram_d = 1'b0;
                    hold_d    = NOP_WORD;
                    valid_d   = 1'b0;
                    mis_d     = 1'b0;
                    oor_d     = 1'b0;
                end else if (!stall) begin
                    mis_d   = 1'b0;
                    oor_d   = 1'b0;
                    valid_d = 1'b0;
                    if (fetch_req) begin
                        sel_ram_d = !fault_mis && !fault_oor;
                        hold_d    = NOP_WORD;
                        valid_d   = !fault_mis && !fault_oor;
                        mis_d     = fault_mis;
                        oor_d     = !fault_mis && fault_oor;
                    end else begin
                        sel_ram_d = 1'b0;
                        hold_d    = instr;
                    end
                end
            end
            default: begin
                if (ram_we) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!prog_mode) begin
                    mode_d = MODE_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_RUN;
            cnt_q     <= '0;
            sel_ram_q <= 1'b0;
            hold_q    <= NOP_WORD;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            sel_ram_q <= sel_ram_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            oor_q     <= oor_d;
        end
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - self-checking bench for inst_mem_sync against a behavioural model
module tb_inst_mem_sync;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, fetch_req, stall, prog_mode, prog_valid;
    logic [9:0]  fetch_addr;
    logic [31:0] prog_data;
    logic [31:0] instr;
    logic        instr_valid, misalign, out_of_range, prog_ready;
    logic [6:0]  prog_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    bit          m_load;
    int          m_cnt;
    logic [31:0] m_instr;
    bit          m_valid, m_mis, m_oor;

    inst_mem_sync #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .instr(instr), .instr_valid(instr_valid), .misalign(misalign), .out_of_range(out_of_range),
        .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .prog_count(prog_count)
    );

    always #5 clk = ~clk;

    // Advance the model by the rules for the inputs present this cycle, then clock the DUT.
    task automatic cycle();
        int idx;
        if (reset) begin
            m_load = 0; m_cnt = 0; m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        end else if (!m_load) begin
            if (prog_mode) begin
                m_load = 1; m_cnt = 0; m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
            end else if (!stall) begin
                m_valid = 0; m_mis = 0; m_oor = 0;
                if (fetch_req) begin
                    idx = int'(fetch_addr) / 4;
                    if (int'(fetch_addr) % 4 != 0) begin
                        m_instr = NOP; m_mis = 1;
                    end else if (idx >= DEPTH) begin
                        m_instr = NOP; m_oor = 1;
                    end else begin
                        m_instr = mem_m[idx]; m_valid = 1;
                    end
                end
            end
        end else begin
            if (prog_valid && m_cnt < DEPTH) begin
                mem_m[m_cnt] = prog_data;
                m_cnt++;
            end
            if (!prog_mode) m_load = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; fetch_req = 0; fetch_addr = '0; stall = 0;
        prog_mode = 0; prog_valid = 0; prog_data = '0;
        cycle(); cycle();
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h want 00000013", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if ({misalign, out_of_range} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", misalign, out_of_range); end
        checks++; if (prog_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", prog_count); end
        checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", prog_ready); end
        reset = 0;
    endtask

    task automatic test_load_fetch();
        logic [31:0] words [3];
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0020_8433;
        prog_mode = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1; prog_data = words[i]; cycle();
            prog_valid = 0; cycle();
        end
        checks++; if (prog_count !== 7'd3) begin errors++; $display("FAIL load_count got %0d want 3", prog_count); end
        checks++; if (instr !== NOP || instr_valid !== 1'b0) begin errors++; $display("FAIL load_nop got %h/%b want %h/0", instr, instr_valid, NOP); end
        prog_mode = 0; cycle();
        fetch_req = 1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 10'(i * 4); cycle();
            checks++; if (instr !== words[i] || instr_valid !== 1'b1) begin
                errors++; $display("FAIL fetch_word%0d got %h/%b want %h/1", i, instr, instr_valid, words[i]);
            end
        end
        fetch_req = 0; cycle();
        checks++; if (instr !== words[2] || instr_valid !== 1'b0) begin errors++; $display("FAIL idle_keep got %h/%b want %h/0", instr, instr_valid, words[2]); end
        checks++; if (prog_count !== 7'd3) begin errors++; $display("FAIL run_count_hold got %0d want 3", prog_count); end
    endtask

    task automatic test_stall();
        fetch_req = 1; fetch_addr = 10'h004; cycle();
        stall = 1; fetch_addr = 10'h008;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (instr !== 32'h0020_0113 || instr_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got %h/%b want 00200113/1", i, instr, instr_valid);
            end
        end
        stall = 0; cycle();
        checks++; if (instr !== 32'h0020_8433) begin errors++; $display("FAIL stall_release got %h want 00208433", instr); end
        fetch_req = 0; cycle();
    endtask

    task automatic test_faults();
        fetch_req = 1; fetch_addr = 10'h006; cycle();
        checks++; if ({misalign, out_of_range, instr_valid} !== 3'b100 || instr !== NOP) begin
            errors++; $display("FAIL misalign got m%b o%b v%b %h want m1 o0 v0 %h", misalign, out_of_range, instr_valid, instr, NOP);
        end
        fetch_addr = 10'h100; cycle();
        checks++; if ({misalign, out_of_range, instr_valid} !== 3'b010 || instr !== NOP) begin
            errors++; $display("FAIL out_of_range got m%b o%b v%b %h want m0 o1 v0 %h", misalign, out_of_range, instr_valid, instr, NOP);
        end
        fetch_addr = 10'h102; cycle();
        checks++; if ({misalign, out_of_range, instr_valid} !== 3'b100) begin
            errors++; $display("FAIL both_faults got m%b o%b v%b want m1 o0 v0", misalign, out_of_range, instr_valid);
        end
        fetch_addr = 10'h000; cycle();
        checks++; if ({misalign, out_of_range, instr_valid} !== 3'b001 || instr !== 32'h0010_0093) begin
            errors++; $display("FAIL fault_recover got m%b o%b v%b %h want m0 o0 v1 00100093", misalign, out_of_range, instr_valid, instr);
        end
        fetch_req = 0; cycle();
    endtask

    task automatic test_full_load();
        prog_mode = 1; cycle();
        for (int i = 0; i < 70; i++) begin
            checks++; if (prog_ready !== (i < DEPTH)) begin errors++; $display("FAIL full_ready%0d got %b want %b", i, prog_ready, i < DEPTH); end
            prog_valid = 1; prog_data = 32'h1000 + 32'(i); cycle();
        end
        checks++; if (prog_count !== 7'd64 || prog_ready !== 1'b0) begin errors++; $display("FAIL full_count got %0d/%b want 64/0", prog_count, prog_ready); end
        prog_valid = 0; prog_mode = 0; cycle();
        fetch_req = 1; fetch_addr = 10'h0FC; cycle();
        checks++; if (instr !== 32'h0000_103F || instr_valid !== 1'b1) begin errors++; $display("FAIL full_last got %h/%b want 0000103f/1", instr, instr_valid); end
        fetch_addr = 10'h000; cycle();
        checks++; if (instr !== 32'h0000_1000) begin errors++; $display("FAIL full_first got %h want 00001000", instr); end
        fetch_req = 0; cycle();
        checks++; if (prog_count !== 7'd64) begin errors++; $display("FAIL full_count_run got %0d want 64", prog_count); end
    endtask

    task automatic test_reset_mid_load();
        prog_mode = 1; cycle();
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1; prog_data = 32'h2000 + 32'(i); cycle();
        end
        reset = 1; prog_data = 32'hDEAD_BEEF; cycle();
        reset = 0; prog_valid = 0; prog_mode = 0;
        checks++; if (prog_count !== 7'd0 || prog_ready !== 1'b0) begin errors++; $display("FAIL midload_reset got %0d/%b want 0/0", prog_count, prog_ready); end
        fetch_req = 1; fetch_addr = 10'h010; cycle();
        checks++; if (instr !== 32'h0000_2004 || instr_valid !== 1'b1) begin errors++; $display("FAIL midload_fifth got %h/%b want 00002004/1", instr, instr_valid); end
        fetch_addr = 10'h014; cycle();
        checks++; if (instr !== 32'h0000_1005) begin errors++; $display("FAIL midload_untouched got %h want 00001005", instr); end
        fetch_req = 0; cycle();
    endtask

    task automatic test_random();
        int n;
        for (int round = 0; round < 6; round++) begin
            prog_mode = 1; prog_valid = 0; cycle();
            n = $urandom_range(0, 80);
            for (int i = 0; i < n; i++) begin
                prog_valid = ($urandom_range(0, 3) != 0);
                prog_data  = $urandom;
                prog_mode  = (i != n - 1);
                fetch_req  = $urandom_range(0, 1);
                fetch_addr = 10'($urandom_range(0, 1023));
                cycle();
                checks++; if ({prog_ready, prog_count} !== {(m_load && m_cnt < DEPTH), 7'(m_cnt)}) begin
                    errors++; $display("FAIL rnd_load r%0d i%0d got %b/%0d want %b/%0d", round, i, prog_ready, prog_count, m_load && m_cnt < DEPTH, m_cnt);
                end
            end
            prog_mode = 0; prog_valid = 0;
            for (int i = 0; i < 150; i++) begin
                fetch_req  = ($urandom_range(0, 3) != 0);
                stall      = ($urandom_range(0, 3) == 0);
                fetch_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63) * 4);
                reset      = ($urandom_range(0, 99) == 0);
                cycle();
                checks++; if ({instr, instr_valid, misalign, out_of_range, prog_count} !== {m_instr, m_valid, m_mis, m_oor, 7'(m_cnt)}) begin
                    errors++; $display("FAIL rnd_run r%0d c%0d got %h v%b m%b o%b n%0d want %h v%b m%b o%b n%0d", round, i,
                        instr, instr_valid, misalign, out_of_range, prog_count, m_instr, m_valid, m_mis, m_oor, m_cnt);
                end
            end
            stall = 0; reset = 0; fetch_req = 0; cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_stall();
        test_faults();
        test_full_load();
        test_reset_mid_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
